// File: rtl/rv_pkg.sv
// Shared definitions for the single-cycle RISC-V core and its instruction
// memory boot loader.
//   NOP_INSTR    : addi x0,x0,0, fed to the core while it is held off memory
//   boot_state_t : boot loader session states
package rv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_COMMIT,
    ST_RUN,
    ST_ERR
  } boot_state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader and port arbiter.
// After a start pulse it takes a little-endian 16-bit word count followed by
// the program bytes, assembles them into 32-bit words and writes them to
// instr_mem. While loading it owns the memory port and feeds the core NOPs;
// once the last word is committed it hands the read port to the core.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse that begins a load session
//   byte_valid/_data    incoming byte stream, byte_ready = accepted this cycle
//   core_fetch_addr     core PC (byte address)
//   core_instr/core_run instruction to the core and run enable
//   mem_addr/mem_instr  instr_mem address and combinational read data
//   mem_we/mem_wdata    instr_mem write strobe and data
//   busy, err           session in progress, sticky length error
module imem_boot_loader
  import rv_pkg::*;
#(
  parameter int          DEPTH = 64,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] core_fetch_addr,
  output logic [31:0] core_instr,
  output logic        core_run,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        err
);

  localparam int          IDX_W    = $clog2(DEPTH) + 1;
  localparam int          PAD_W    = 32 - IDX_W - 2;
  localparam logic [15:0] DEPTH_16 = 16'(DEPTH);

  boot_state_t      state_q, state_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      asm_q, asm_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             byte_take;
  logic [15:0]      count;

  assign byte_ready = (state_q inside {ST_LEN0, ST_LEN1, ST_DATA});
  assign busy       = (state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_COMMIT});
  assign core_run   = (state_q == ST_RUN);
  assign err        = (state_q == ST_ERR);
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_instr = (state_q == ST_RUN) ? mem_instr : NOP;
  assign byte_take  = byte_valid && byte_ready;
  assign count      = {byte_data, len_lo_q};

  // The write address is latched separately because word_idx has already
  // advanced by the time the write strobe is on the port.
  always_comb begin
    if (mem_we_q) begin
      mem_addr = {{PAD_W{1'b0}}, wr_idx_q, 2'b00};
    end else if (state_q == ST_RUN) begin
      mem_addr = core_fetch_addr;
    end else begin
      mem_addr = {{PAD_W{1'b0}}, word_idx_q, 2'b00};
    end
  end

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    wr_idx_d    = wr_idx_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    len_lo_d    = len_lo_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN0;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      ST_LEN0: begin
        if (byte_take) begin
          len_lo_d = byte_data;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_take) begin
          if (count == 16'd0 || count > DEPTH_16) begin
            state_d = ST_ERR;
          end else begin
            len_d   = count[IDX_W-1:0];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_take) begin
          if (byte_idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {byte_data, asm_q};
            wr_idx_d    = word_idx_q;
            word_idx_d  = word_idx_q + 1'b1;
            byte_idx_d  = 2'd0;
            if (word_idx_q == len_q - 1'b1) begin
              state_d = ST_COMMIT;
            end
          end else begin
            // Shift right so byte 0 ends up in bits 7:0 after three bytes.
            asm_d      = {byte_data, asm_q[23:8]};
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= '0;
      wr_idx_q    <= '0;
      len_q       <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      len_lo_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      wr_idx_q    <= wr_idx_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      len_lo_q    <= len_lo_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: a cycle-by-cycle vector table for the main
// load/run/reload flow, then hand-written sequences for length errors,
// gapped byte streams, an ignored start and a mid-session reset.
module tb_imem_boot_loader;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic [31:0] core_fetch_addr = 32'h0;
  logic [31:0] core_instr;
  logic        core_run;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        err;

  int n_vectors = 0;
  int n_miscompares = 0;
  int we_count = 0;
  int we_double = 0;
  logic we_prev = 1'b0;

  logic [31:0] mem [64];

  imem_boot_loader #(.DEPTH(64), .NOP(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .core_fetch_addr(core_fetch_addr), .core_instr(core_instr),
    .core_run(core_run), .mem_addr(mem_addr), .mem_instr(mem_instr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Instruction memory model with a combinational read port.
  assign mem_instr = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      we_count = we_count + 1;
    end
    if (mem_we && we_prev) we_double = we_double + 1;
    we_prev = mem_we;
  end

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic [31:0] fa;
    logic        rdy;
    logic        bsy;
    logic        run;
    logic        er;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] instr;
  } tv_t;

  tv_t tbl[$];

  function automatic tv_t mk(input logic s, input logic v, input logic [7:0] d,
                             input logic [31:0] fa, input logic rdy, input logic bsy,
                             input logic run, input logic er, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] instr);
    tv_t t;
    t.s = s; t.v = v; t.d = d; t.fa = fa;
    t.rdy = rdy; t.bsy = bsy; t.run = run; t.er = er; t.we = we;
    t.addr = addr; t.wdata = wdata; t.instr = instr;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input tv_t t);
    checkOutput({tag, ".byte_ready"}, {31'b0, byte_ready}, {31'b0, t.rdy});
    checkOutput({tag, ".busy"},       {31'b0, busy},       {31'b0, t.bsy});
    checkOutput({tag, ".core_run"},   {31'b0, core_run},   {31'b0, t.run});
    checkOutput({tag, ".err"},        {31'b0, err},        {31'b0, t.er});
    checkOutput({tag, ".mem_we"},     {31'b0, mem_we},     {31'b0, t.we});
    checkOutput({tag, ".mem_addr"},   mem_addr,   t.addr);
    checkOutput({tag, ".mem_wdata"},  mem_wdata,  t.wdata);
    checkOutput({tag, ".core_instr"}, core_instr, t.instr);
  endtask

  task automatic applyStimulus(input tv_t t);
    @(negedge clk);
    start = t.s;
    byte_valid = t.v;
    byte_data = t.d;
    core_fetch_addr = t.fa;
    #1;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offers a byte until it is taken; returns with byte_valid low just after
  // the accepting edge.
  task automatic pushByte(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data = d;
      #1;
      if (byte_ready) ok = 1'b1;
    end
    checkOutput("push_accept", {31'b0, ok}, 32'd1);
    if (ok) @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic waitRun(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (core_run) seen = 1'b1;
    end
    checkOutput(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic fetchCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    core_fetch_addr = a;
    #1;
    checkOutput(tag, core_instr, exp);
  endtask

  tv_t rst_vec;
  int  wc;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst_vec = mk(0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR);

    // Main flow: N=3 load, fetches in RUN, reload with N=1 from RUN.
    tbl.push_back(mk(0, 0, 8'h00, 32'h00, 0, 0, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(0, 0, 8'h00, 32'h60, 0, 0, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(1, 0, 8'h00, 32'h00, 0, 0, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h03, 32'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h00, 32'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h13, 32'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h05, 32'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'ha0, 32'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h00, 32'h00, 1, 1, 0, 0, 0, 32'h0, 32'h0, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h93, 32'h00, 1, 1, 0, 0, 1, 32'h0, 32'h00a00513, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h05, 32'h00, 1, 1, 0, 0, 0, 32'h4, 32'h00a00513, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h50, 32'h00, 1, 1, 0, 0, 0, 32'h4, 32'h00a00513, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h00, 32'h00, 1, 1, 0, 0, 0, 32'h4, 32'h00a00513, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h33, 32'h00, 1, 1, 0, 0, 1, 32'h4, 32'h00500593, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h86, 32'h00, 1, 1, 0, 0, 0, 32'h8, 32'h00500593, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'hb5, 32'h00, 1, 1, 0, 0, 0, 32'h8, 32'h00500593, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h00, 32'h00, 1, 1, 0, 0, 0, 32'h8, 32'h00500593, NOP_INSTR));
    tbl.push_back(mk(0, 0, 8'h00, 32'h00, 0, 1, 0, 0, 1, 32'h8, 32'h00b58633, NOP_INSTR));
    tbl.push_back(mk(0, 0, 8'h00, 32'h04, 0, 0, 1, 0, 0, 32'h4, 32'h00b58633, 32'h00500593));
    tbl.push_back(mk(0, 0, 8'h00, 32'h00, 0, 0, 1, 0, 0, 32'h0, 32'h00b58633, 32'h00a00513));
    tbl.push_back(mk(0, 0, 8'h00, 32'h08, 0, 0, 1, 0, 0, 32'h8, 32'h00b58633, 32'h00b58633));
    tbl.push_back(mk(1, 0, 8'h00, 32'h04, 0, 0, 1, 0, 0, 32'h4, 32'h00b58633, 32'h00500593));
    tbl.push_back(mk(0, 1, 8'h01, 32'h04, 1, 1, 0, 0, 0, 32'h0, 32'h00b58633, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h00, 32'h04, 1, 1, 0, 0, 0, 32'h0, 32'h00b58633, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h78, 32'h04, 1, 1, 0, 0, 0, 32'h0, 32'h00b58633, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h56, 32'h04, 1, 1, 0, 0, 0, 32'h0, 32'h00b58633, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h34, 32'h04, 1, 1, 0, 0, 0, 32'h0, 32'h00b58633, NOP_INSTR));
    tbl.push_back(mk(0, 1, 8'h12, 32'h04, 1, 1, 0, 0, 0, 32'h0, 32'h00b58633, NOP_INSTR));
    tbl.push_back(mk(0, 0, 8'h00, 32'h00, 0, 1, 0, 0, 1, 32'h0, 32'h12345678, NOP_INSTR));
    tbl.push_back(mk(0, 0, 8'h00, 32'h00, 0, 0, 1, 0, 0, 32'h0, 32'h12345678, 32'h12345678));
    tbl.push_back(mk(0, 0, 8'h00, 32'h08, 0, 0, 1, 0, 0, 32'h8, 32'h12345678, 32'h00b58633));

    #3;
    checkAll("reset", rst_vec);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkAll($sformatf("row%0d", i), tbl[i]);
    end
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b0;

    // Length errors: N=0 then N=DEPTH+1, neither may write memory.
    wc = we_count;
    pulseStart();
    pushByte(8'h00);
    pushByte(8'h00);
    @(negedge clk); #1;
    checkOutput("len0.err",        {31'b0, err},        32'd1);
    checkOutput("len0.byte_ready", {31'b0, byte_ready}, 32'd0);
    checkOutput("len0.busy",       {31'b0, busy},       32'd0);
    checkOutput("len0.core_run",   {31'b0, core_run},   32'd0);
    checkOutput("len0.core_instr", core_instr,          NOP_INSTR);
    pulseStart();
    @(negedge clk); #1;
    checkOutput("len0.err_clear",  {31'b0, err},        32'd0);
    checkOutput("len0.ready_len",  {31'b0, byte_ready}, 32'd1);
    pushByte(8'h41);
    pushByte(8'h00);
    @(negedge clk); #1;
    checkOutput("len65.err",       {31'b0, err},        32'd1);
    checkOutput("len_err.no_we",   we_count,            wc);
    pulseStart();
    @(negedge clk); #1;
    checkOutput("len65.err_clear", {31'b0, err},        32'd0);

    // Gapped stream, N=2, starting from the LEN0 left by the last start.
    wc = we_count;
    we_double = 0;
    pushByte(8'h02); @(negedge clk);
    pushByte(8'h00); @(negedge clk);
    pushByte(8'hef); @(negedge clk);
    pushByte(8'hbe); @(negedge clk);
    pushByte(8'had); @(negedge clk);
    pushByte(8'hde); @(negedge clk);
    pushByte(8'h0d); @(negedge clk);
    pushByte(8'hf0); @(negedge clk);
    pushByte(8'hfe); @(negedge clk);
    pushByte(8'hca);
    waitRun("gap.run");
    checkOutput("gap.we_count",  we_count - wc, 32'd2);
    checkOutput("gap.we_single", we_double,     32'd0);
    fetchCheck("gap.word0", 32'h0, 32'hdeadbeef);
    fetchCheck("gap.word1", 32'h4, 32'hcafef00d);

    // A start pulse in DATA must not restart the session.
    pulseStart();
    pushByte(8'h02);
    pushByte(8'h00);
    pushByte(8'h44);
    pushByte(8'h33);
    pulseStart();
    @(negedge clk); #1;
    checkOutput("ign.busy",       {31'b0, busy},       32'd1);
    checkOutput("ign.byte_ready", {31'b0, byte_ready}, 32'd1);
    pushByte(8'h22);
    pushByte(8'h11);
    pushByte(8'h88);
    pushByte(8'h77);
    pushByte(8'h66);
    pushByte(8'h55);
    waitRun("ign.run");
    fetchCheck("ign.word0", 32'h0, 32'h11223344);
    fetchCheck("ign.word1", 32'h4, 32'h55667788);

    // Reset after 6 data bytes of a 3-word load, then a clean N=1 load.
    pulseStart();
    pushByte(8'h03);
    pushByte(8'h00);
    pushByte(8'ha1);
    pushByte(8'ha2);
    pushByte(8'ha3);
    pushByte(8'ha4);
    pushByte(8'hb1);
    pushByte(8'hb2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAll("midrst", rst_vec);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst.run_low", {31'b0, core_run}, 32'd0);
    pulseStart();
    pushByte(8'h01);
    pushByte(8'h00);
    pushByte(8'h0d);
    pushByte(8'hf0);
    pushByte(8'had);
    pushByte(8'h0b);
    waitRun("reload.run");
    fetchCheck("reload.word0", 32'h0, 32'h0badf00d);
    fetchCheck("reload.word1", 32'h4, 32'h55667788);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
